// File: rtl/roc_collect.sv
// -----------------------------------------------------------------------------
// roc_collect
//
// Harvester stage that sits after the RO-race bit extractor in the TRNG path.
// It sequences the extractor's reset/start controls and brings the
// asynchronous busy flag into the clk domain. It takes one raw bit per race
// from ro_rdata[0] and packs the accepted bits into WORD-bit words. Each word
// is presented on a valid/ready output.
//
// Optional feature macro: ROC_COLLECT_VN_EN
//   defined   -> Von Neumann debiasing on consecutive raw bit pairs
//   undefined -> every raw bit is accepted directly
//
// Parameters
//   Nbc      width of the extractor data bus (only bit 0 is used)
//   WORD     output word width (>= 2)
//   RST_CYC  cycles ro_rst is held high before each race (>= 1)
//   TO_CYC   timeout budget in clk cycles across ARM + RUN (16-bit counter)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         enable harvesting
//   ro_rst     extractor reset (registered)
//   ro_str     extractor start (registered)
//   ro_busy    extractor busy, asynchronous to clk
//   ro_rdata   extractor data; bit 0 is the race result
//   out_data   harvested word (registered)
//   out_valid  out_data is valid (registered)
//   out_ready  consumer accepts the word
//   err        sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module roc_collect #(
  parameter int Nbc     = 14,
  parameter int WORD    = 32,
  parameter int RST_CYC = 4,
  parameter int TO_CYC  = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            ro_rst,
  output logic            ro_str,
  input  logic            ro_busy,
  input  logic [Nbc-1:0]  ro_rdata,
  output logic [WORD-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err
);

  localparam int              CW       = $clog2(WORD) + 1;
  localparam logic [15:0]     RST_LAST = 16'(RST_CYC - 1);
  localparam logic [15:0]     TO_LIM   = 16'(TO_CYC);
  localparam logic [CW-1:0]   BIT_LAST = CW'(WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETUP,
    S_START,
    S_ARM,
    S_RUN,
    S_SAMPLE,
    S_DELIVER
  } state_t;

  state_t          state, state_nxt;
  logic            busy_m, busy_s;
  logic [15:0]     cnt, cnt_nxt;
  logic [WORD-1:0] sreg;
  logic [CW-1:0]   bit_cnt;
  logic            raw_bit;
  logic            acc, acc_bit;
  logic            word_full;
  logic            timeout;
  logic            abort;
  logic            load;

  // Upper data bits are deliberately ignored.
  logic unused_rdata;
  assign unused_rdata = ^ro_rdata[Nbc-1:1];

  assign raw_bit = ro_rdata[0];

  // ---------------------------------------------------------------------------
  // Busy synchroniser (2 FF). ro_busy has no timing relation to clk.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= ro_busy;
      busy_s <= busy_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit stage: decides whether the current raw bit yields an accepted bit.
  // ---------------------------------------------------------------------------
`ifdef ROC_COLLECT_VN_EN
  logic pair_vld;
  logic pair_bit;

  // 01 -> 0, 10 -> 1: the accepted bit is always the first bit of the pair.
  always_comb begin
    acc     = pair_vld && (pair_bit != raw_bit);
    acc_bit = pair_bit;
  end
`else
  always_comb begin
    acc     = 1'b1;
    acc_bit = raw_bit;
  end
`endif

  assign word_full = acc && (bit_cnt == BIT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:    if (en) state_nxt = S_RESET;
      S_RESET:   if (cnt == RST_LAST) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = S_START;
      S_START:   if (cnt == 16'd1) state_nxt = S_ARM;
      S_ARM: begin
        if (cnt == TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = S_RESET;
        end else if (busy_s) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = S_RESET;
        end else if (!busy_s) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (word_full) state_nxt = S_DELIVER;
        else           state_nxt = en ? S_RESET : S_IDLE;
      end
      // Wait for the previous word to drain; en is only honoured after the load.
      S_DELIVER: if (!out_valid) state_nxt = en ? S_RESET : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase

    // Losing en outside IDLE/DELIVER aborts the partial word immediately.
    if (!en && (state != S_IDLE) && (state != S_DELIVER)) begin
      abort     = 1'b1;
      timeout   = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  // One counter serves RESET/START durations and the ARM+RUN timeout. It is
  // cleared on every state change except ARM->RUN, so the timeout budget spans
  // both states; it holds in SAMPLE once the race is over.
  always_comb begin
    cnt_nxt = cnt;
    if ((state_nxt != state) && !((state == S_ARM) && (state_nxt == S_RUN)))
      cnt_nxt = '0;
    else if (state inside {S_RESET, S_START, S_ARM, S_RUN})
      cnt_nxt = cnt + 16'd1;
  end

  assign load = (state == S_DELIVER) && !out_valid;

  // ---------------------------------------------------------------------------
  // Extractor controls, registered from the next state so they line up with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_rst <= 1'b1;
      ro_str <= 1'b0;
    end else begin
      ro_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RESET);
      ro_str <= (state_nxt == S_START);
    end
  end

  // ---------------------------------------------------------------------------
  // Packing: shift right so the first accepted bit ends in bit 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (abort) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if ((state == S_SAMPLE) && acc) begin
      sreg    <= {acc_bit, sreg[WORD-1:1]};
      bit_cnt <= bit_cnt + CW'(1);
    end else if (load) begin
      bit_cnt <= '0;
    end
  end

`ifdef ROC_COLLECT_VN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_vld <= 1'b0;
      pair_bit <= 1'b0;
    end else if (abort || timeout) begin
      pair_vld <= 1'b0;
    end else if (state == S_SAMPLE) begin
      pair_vld <= !pair_vld;
      if (!pair_vld) pair_bit <= raw_bit;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output word and error flag. A load only happens with out_valid low, so it
  // never coincides with a handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= sreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_roc_collect.sv
// -----------------------------------------------------------------------------
// tb_roc_collect
//
// Directed bench for roc_collect (TO_CYC = 100). An extractor model answers
// each ro_str pulse: busy rises about 3 cycles later and falls 20 cycles after
// that, and a raw bit is taken from a queue. A queue entry of 2 means the
// extractor never raises busy. Words are described as accepted bits; with
// ROC_COLLECT_VN_EN each accepted bit is encoded as a raw pair.
// -----------------------------------------------------------------------------
module tb_roc_collect;

  localparam int NBC  = 14;
  localparam int WORD = 32;
`ifdef ROC_COLLECT_VN_EN
  localparam int RPB  = 2;
`else
  localparam int RPB  = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            ro_rst;
  logic            ro_str;
  logic            ro_busy;
  logic [NBC-1:0]  ro_rdata;
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  int raw_q[$];
  int str_pulses = 0;
  bit in_race    = 1'b0;
  int str_bad    = 0;
  int gap_bad    = 0;
  int mon_len    = 0;
  logic mon_sp   = 1'b0;
  logic mon_rp   = 1'b1;
  logic m_prev   = 1'b0;

  always #5 clk = ~clk;

  roc_collect #(
    .Nbc     (NBC),
    .WORD    (WORD),
    .RST_CYC (4),
    .TO_CYC  (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ro_rst    (ro_rst),
    .ro_str    (ro_str),
    .ro_busy   (ro_busy),
    .ro_rdata  (ro_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_bit(input logic b);
`ifdef ROC_COLLECT_VN_EN
    if (b) begin raw_q.push_back(1); raw_q.push_back(0); end
    else   begin raw_q.push_back(0); raw_q.push_back(1); end
`else
    raw_q.push_back(b ? 1 : 0);
`endif
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) push_bit(w[i]);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!out_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int max_cyc);
    int n = 0;
    while (str_pulses < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, str_pulses, target);
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while (in_race && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    wait_model_idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    raw_q.delete();
  endtask

  // Extractor model.
  initial begin
    int v;
    ro_busy  = 1'b0;
    ro_rdata = '0;
    forever begin
      @(negedge clk);
      if (ro_str && !m_prev) begin
        str_pulses++;
        v = (raw_q.size() > 0) ? raw_q.pop_front() : 0;
        if (v != 2) begin
          in_race = 1'b1;
          repeat (2) @(negedge clk);
          ro_rdata    = '0;
          ro_rdata[0] = v[0];
          ro_busy     = 1'b1;
          repeat (20) @(negedge clk);
          ro_busy = 1'b0;
          in_race = 1'b0;
        end
      end
      m_prev = ro_str;
    end
  end

  // Protocol monitor: ro_str lasts 2 cycles and rises only after ro_rst is low.
  initial begin
    forever begin
      @(negedge clk);
      if (ro_str && !mon_sp && mon_rp) gap_bad++;
      if (ro_str) mon_len++;
      else begin
        if (mon_sp && mon_len != 2) str_bad++;
        mon_len = 0;
      end
      mon_sp = ro_str;
      mon_rp = ro_rst;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int changes;

    rst       = 1'b1;
    en        = 1'b0;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_ro_rst",    32'(ro_rst),    32'd1);
    check("rst_ro_str",    32'(ro_str),    32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ro_rst", 32'(ro_rst), 32'd1);

    // ---------------- nominal: alternating 1,0 ----------------
    for (int i = 0; i < 16; i++) begin
      push_bit(1'b1);
      push_bit(1'b0);
    end
    base = str_pulses;
    en   = 1'b1;
    wait_valid("nom_valid", 5000);
    check("nom_data",  out_data,          32'h5555_5555);
    check("nom_races", str_pulses - base, 32 * RPB);

    // ---------------- abort during RUN ----------------
    do_reset();
    for (int i = 0; i < 8; i++) push_bit(1'b1);
    base = str_pulses;
    en   = 1'b1;
    wait_pulses("abort_pulses", base + 4, 2000);
    n = 0;
    while (!ro_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_ro_rst", 32'(ro_rst), 32'd1);
    check("abort_ro_str", 32'(ro_str), 32'd0);
    wait_model_idle();
    repeat (10) @(negedge clk);
    check("abort_no_valid", 32'(out_valid), 32'd0);
    raw_q.delete();
    push_word(32'hC3A5_0F96);
    base = str_pulses;
    en   = 1'b1;
    wait_valid("abort_valid", 5000);
    check("abort_data",  out_data,          32'hC3A5_0F96);
    check("abort_races", str_pulses - base, 32 * RPB);

    // ---------------- backpressure ----------------
    do_reset();
    out_ready = 1'b0;
    push_word(32'h3333_3333);
    push_word(32'hFFFF_FFFF);
    push_word(32'hAAAA_AAAA);
    base = str_pulses;
    en   = 1'b1;
    wait_valid("bp_valid1", 5000);
    check("bp_data1", out_data, 32'h3333_3333);
    changes = 0;
    n       = 0;
    while (!((str_pulses - base >= 64 * RPB) && !in_race) && n < 6000) begin
      @(negedge clk);
      n++;
      if (out_data !== 32'h3333_3333 || !out_valid) changes++;
    end
    repeat (200) begin
      @(negedge clk);
      if (out_data !== 32'h3333_3333 || !out_valid) changes++;
    end
    check("bp_stable",   changes,           0);
    check("bp_no_str",   str_pulses - base, 64 * RPB);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_drop",  32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp_valid2",   32'(out_valid), 32'd1);
    check("bp_data2",    out_data,       32'hFFFF_FFFF);
    @(negedge clk);
    check("bp_hs2_drop", 32'(out_valid), 32'd0);
    wait_valid("bp_valid3", 5000);
    check("bp_data3",    out_data,       32'hAAAA_AAAA);

    // ---------------- timeout: busy stuck low ----------------
    do_reset();
    for (int i = 0; i < 4; i++) push_bit(1'b1);
    raw_q.push_back(2);
    for (int i = 0; i < 28; i++) push_bit(1'b0);
    base = str_pulses;
    en   = 1'b1;
    wait_pulses("to_pulses", base + 4 * RPB + 1, 3000);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_err",     32'(err),                        32'd1);
    check("to_latency", 32'((n >= 100) && (n <= 106)),   32'd1);
    check("to_ro_rst",  32'(ro_rst),                     32'd1);
    wait_valid("to_valid", 5000);
    check("to_data",    out_data,          32'h0000_000F);
    check("to_races",   str_pulses - base, 32 * RPB + 1);

    // ---------------- async reset mid-RUN ----------------
    n = 0;
    while (!ro_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ro_rst",    32'(ro_rst),    32'd1);
    check("arst_ro_str",    32'(ro_str),    32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  out_data,       32'h0);
    check("arst_err",       32'(err),       32'd0);
    en = 1'b0;
    wait_model_idle();
    @(negedge clk);
    rst = 1'b0;
    raw_q.delete();
    push_word(32'h1234_5678);
    base = str_pulses;
    en   = 1'b1;
    wait_valid("arst_valid", 5000);
    check("arst_races", str_pulses - base, 32 * RPB);
    check("arst_data",  out_data,          32'h1234_5678);

    // ---------------- raw stream 0,1,1,0,1,1,0,0 ----------------
    do_reset();
    raw_q.push_back(0); raw_q.push_back(1); raw_q.push_back(1); raw_q.push_back(0);
    raw_q.push_back(1); raw_q.push_back(1); raw_q.push_back(0); raw_q.push_back(0);
    base = str_pulses;
`ifdef ROC_COLLECT_VN_EN
    for (int i = 0; i < 30; i++) push_bit(1'b1);
    en = 1'b1;
    wait_valid("vn_valid", 6000);
    check("vn_data",  out_data,          32'hFFFF_FFFE);
    check("vn_races", str_pulses - base, 68);
`else
    for (int i = 0; i < 12; i++) begin
      raw_q.push_back(1);
      raw_q.push_back(0);
    end
    en = 1'b1;
    wait_valid("vn_valid", 6000);
    check("vn_data",  out_data,          32'h5555_5536);
    check("vn_races", str_pulses - base, 32);
`endif

    // ---------------- protocol monitor ----------------
    check("str_width",   str_bad, 0);
    check("rst_str_gap", gap_bad, 0);

    en = 1'b0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/roc_collect.md
# roc_collect

Harvester stage downstream of the RO-race bit extractor in the TRNG path. It runs on the system clock and sequences the extractor's `rst`/`str` controls. It synchronises the extractor's asynchronous `busy` output and takes one raw bit per race from `rdata[0]`. It packs the accepted bits into WORD-bit words and delivers them on a valid/ready output.

## Interface
- `Nbc`, 14: width of the extractor `rdata` bus.
- `WORD`, 32: output word width, ≥2.
- `RST_CYC`, 4: cycles `ro_rst` is held high before each race, ≥1.
- `TO_CYC`, 65535: timeout budget in clk cycles, covering ARM plus RUN; 16-bit counter.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `en` in 1: enable harvesting.
- `ro_rst` out 1: drives the extractor reset.
- `ro_str` out 1: drives the extractor start.
- `ro_busy` in 1: extractor busy; asynchronous to clk.
- `ro_rdata` in Nbc: extractor data; only bit 0 is used.
- `out_data` out WORD: harvested word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word.
- `err` out 1: sticky timeout flag.

## Operation
- `ro_busy` passes through a 2-FF synchroniser; `busy_s` is its output.
- FSM states and transitions:
  - IDLE → RESET when `en`=1.
  - RESET: `ro_rst`=1 for RST_CYC cycles → SETUP.
  - SETUP: `ro_rst`=0, `ro_str`=0 for 1 cycle → START.
  - START: `ro_str`=1 for 2 cycles → ARM.
  - ARM: wait for `busy_s`=1 → RUN.
  - RUN: wait for `busy_s`=0 → SAMPLE.
  - SAMPLE: register `ro_rdata[0]` (counters are frozen once the race completes), pass it to the bit stage → DELIVER if the shift register holds WORD bits, otherwise RESET (or IDLE if `en`=0).
  - DELIVER: wait until `out_valid`=0, copy the shift register to `out_data`, set `out_valid`, clear the bit count → RESET (or IDLE if `en`=0).
- Bit packing: the first accepted bit lands in `out_data[0]`, and later bits fill ascending positions.
  - Shift register: WORD bits.
  - Bit count: clog2(WORD)+1 bits.
- Timeout: the counter is cleared on entry to ARM and counts through ARM and RUN. When it reaches TO_CYC:
  - `err` is set;
  - the race result is discarded;
  - the FSM goes to RESET and retries.
  - `err` clears only on `rst`.
- `en` falling while in any state other than IDLE or DELIVER:
  - next state is IDLE;
  - the partial word and the VN pair register are discarded;
  - `out_valid`/`out_data` are unaffected.
- In DELIVER, `en`=0 takes effect after the load.
- In IDLE, `ro_rst`=1 and `ro_str`=0, so the extractor is held reset.

## Timing
- Reset values:
  - `ro_rst`=1, `ro_str`=0;
  - `out_valid`=0, `out_data`=0;
  - `err`=0;
  - FSM in IDLE, counters 0.
- All outputs are registered.
- `out_valid` falls on the clk edge where `out_valid`&&`out_ready`.
- A load into DELIVER and a same-cycle handshake: the handshake completes first, and the new word is loaded on the following edge.
- `out_data` is stable while `out_valid`&&!`out_ready`.
- Race overhead excluding race duration: RST_CYC+1+2 cycles before the race, plus 2 cycles of synchroniser latency on each busy edge, plus 1 SAMPLE cycle.
- The `ro_busy` falling edge reaches SAMPLE in ≥3 clk cycles, which is the settling margin for `ro_rdata`.
- `ro_rst` deasserts ≥1 cycle before `ro_str` rises.
- `ro_str` high lasts exactly 2 cycles.

## Configuration
- `ROC_COLLECT_VN_EN` defined: Von Neumann debiasing on consecutive raw bits.
  - The first bit of a pair is held in the pair register.
  - 01 → accept 0; 10 → accept 1; 00 and 11 → accept nothing.
  - The pair register is cleared after every second bit and on timeout.
- Not defined: every raw bit from SAMPLE is accepted directly.

## Test plan
- Reset: assert `rst` mid-RUN → asynchronously `ro_rst`=1, `ro_str`=0, `out_valid`=0, `err`=0, and no `out_valid` appears until after a full word of races.
- Nominal, macro off:
  - extractor model raises busy 3 cycles after `ro_str` and drops it 20 cycles later;
  - raw bits alternate 1,0,…;
  - with `out_ready`=1 → `out_data`=0x55555555 after 32 races.
- Backpressure: `out_ready`=0 for 3 words → first word held stable, second word waits in DELIVER, and no `ro_str` pulse occurs until `out_ready`=1.
- Timeout: TO_CYC=100 and `ro_busy` stuck at 0 → `err`=1 about 100 cycles after ARM entry, `ro_rst` reasserted, bit count unchanged.
- VN:
  - raw stream 0,1,1,0,1,1,0,0 with macro defined → exactly 2 bits accepted (0, then 1);
  - same stream with macro undefined → 8 bits accepted.
- Abort: drop `en` during RUN → IDLE next cycle, `ro_rst`=1, partial word lost; re-enabling restarts the bit count at 0.
